// File: rtl/pattern_detector_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic {
    S_FILL,
    S_ARMED
  } state_e;

  // Width of the fill counter, which must hold values 0..pat_w.
  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pd_sat_counter.sv
// Saturating match counter with a sticky overflow flag; clear has priority over increment.
module pd_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] count_q;
  logic             sat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (inc_i) begin
      // At all-ones the count holds and the extra match is recorded in sat.
      if (count_q == '1) begin
        sat_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/pattern_detector_param.sv
// Serial bit-pattern detector with run-time loadable pattern and overlap mode.
module pattern_detector_param
  import pattern_detector_pkg::*;
#(
  parameter int unsigned      PAT_W           = 5,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [PAT_W-1:0] PAT_DEFAULT     = 5'b10110,
  parameter logic             OVERLAP_DEFAULT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             d_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap_i,
  input  logic             clear_i,
  output logic             pattern_o,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam int unsigned      FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_e            state_q;
  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic              pattern_q;

  logic              accept_d;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_d;
  logic              match_d;

  // The fill counter only saturates in S_ARMED, so the state selects the saturated value.
  always_comb begin
    accept_d = valid_i & ~cfg_load_i;
    hist_d   = {hist_q[PAT_W-2:0], d_i};
    fill_d   = (state_q == S_ARMED) ? FILL_FULL : fill_q + 1'b1;
    match_d  = accept_d && (fill_d == FILL_FULL) && (hist_d == pat_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= PAT_DEFAULT;
      ovl_q     <= OVERLAP_DEFAULT;
      pattern_q <= 1'b0;
    end else begin
      pattern_q <= match_d;
      if (cfg_load_i) begin
        pat_q   <= pattern_i;
        ovl_q   <= overlap_i;
        hist_q  <= '0;
        fill_q  <= '0;
        state_q <= S_FILL;
      end else if (accept_d) begin
        if (match_d && !ovl_q) begin
          hist_q  <= '0;
          fill_q  <= '0;
          state_q <= S_FILL;
        end else begin
          hist_q  <= hist_d;
          fill_q  <= fill_d;
          state_q <= (fill_d == FILL_FULL) ? S_ARMED : S_FILL;
        end
      end
    end
  end

  pd_sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (match_d),
    .clr_i  (clear_i),
    .count_o(count_o),
    .sat_o  (sat_o)
  );

  assign pattern_o = pattern_q;

endmodule

// File: doc/pattern_detector_param.md
Name: pattern_detector_param

Overview:
Parametrised serial bit-pattern detector and successor to the fixed-pattern non-overlapping Moore detector. It accepts one qualified bit per cycle (valid_i/d_i) and compares the last PAT_W accepted bits against a run-time loadable pattern. Overlapping or non-overlapping matching is selectable at run time. It produces a registered one-cycle match pulse, a saturating match counter and a sticky saturation flag. It sits between a serial bit source and status/interrupt logic.

Parameters:
PAT_W, 5, pattern length in bits; legal range 2..32
CNT_W, 16, width of match counter
PAT_DEFAULT, 5'b10110, pattern loaded at reset; width PAT_W; bit PAT_W-1 is the first bit received
OVERLAP_DEFAULT, 0, match mode at reset; 1 = overlapping, 0 = non-overlapping

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
valid_i  input  1  d_i is qualified this cycle
d_i  input  1  serial data bit
cfg_load_i  input  1  load pattern_i/overlap_i into shadow registers and flush bit history
pattern_i  input  PAT_W  new pattern; MSB is the first bit of the sequence
overlap_i  input  1  new mode; 1 = overlap, 0 = non-overlap
clear_i  input  1  synchronous clear of count_o and sat_o
pattern_o  output  1  registered match pulse
count_o  output  CNT_W  number of matches since reset/clear, saturating
sat_o  output  1  sticky flag: count_o reached all-ones and a further match occurred

Behaviour:
- Reset (asynchronous, active-high):
  - pattern_o=0, count_o=0, sat_o=0.
  - Shift history=0, fill=0, state=S_FILL.
  - Pattern register=PAT_DEFAULT; mode register=OVERLAP_DEFAULT.
- Internal state: history shift register hist[PAT_W-1:0]; fill counter fill (0..PAT_W, saturating); FSM {S_FILL, S_ARMED}.
- Accepted bit: valid_i=1 and cfg_load_i=0 at a rising edge. On acceptance:
  - next history nh = {hist[PAT_W-2:0], d_i}
  - next fill nf = min(fill+1, PAT_W)
- Match condition, evaluated at the accepting edge: nf==PAT_W and nh==pattern register.
- pattern_o is registered (Moore):
  - It is 1 in the cycle immediately after the edge that accepted the final matching bit.
  - It is 0 otherwise. Latency from the last bit sampled to pattern_o high is 1 clock.
  - Back-to-back matches in overlap mode give consecutive high cycles (e.g. pattern 11111 with a stream of ones).
- On match, overlap mode: history kept; fill stays PAT_W; state stays S_ARMED.
- On match, non-overlap mode: fill and history cleared to 0; state goes to S_FILL. The next match needs PAT_W fresh accepted bits.
- FSM transitions:
  - S_FILL -> S_ARMED when nf==PAT_W without a non-overlap match.
  - S_ARMED -> S_FILL on a non-overlap match or on cfg_load_i.
- valid_i=0: history, fill and state hold; pattern_o=0 next cycle. Gaps of any length are transparent.
- cfg_load_i=1:
  - Loads the pattern and mode registers.
  - Clears history and fill; state goes to S_FILL; pattern_o=0 next cycle.
  - Any bit presented the same cycle is discarded, even if valid_i=1.
  - count_o and sat_o are unaffected.
- pattern_i and overlap_i are ignored when cfg_load_i=0. Changing them has no effect until the next load.
- Counter:
  - count_o increments at the same edge pattern_o is set.
  - At all-ones it holds, and a further match sets sat_o=1.
  - sat_o is cleared only by clear_i or reset.
- clear_i: count_o=0 and sat_o=0 at the next edge.
  - If clear_i and a match coincide, clear wins: count_o=0, sat_o unchanged-to-0; pattern_o still pulses.
- Reset mid-stream discards a partial sequence; no match can complete using bits accepted before reset.

Decomposition:
- Package pattern_detector_pkg:
  - state enum {S_FILL, S_ARMED}
  - localparam FILL_W = $clog2(PAT_W+1)
- One sub-module, pd_sat_counter: parameter CNT_W; inputs inc, clr; outputs count and sticky sat. It implements the saturating count_o/sat_o logic.
- Shift/compare and the FSM stay in the top module.

Test Plan:
- PAT_W=4, pattern 1011, overlap=1, accepted stream 1,0,1,1,0,1,1 -> pattern_o pulses the cycle after bit 4 and after bit 7; count_o=2.
- Same pattern and stream with overlap=0 -> single pulse after bit 4; count_o=1.
- Stream 1,0,1,1,1,0,1,1 with overlap=0 -> pulses after bits 4 and 8; count_o=2.
- Stream 1,0, then valid_i=0 for 3 cycles, then 1,1 -> one pulse after the 4th accepted bit; no pulse during the gap.
- CNT_W=3, pattern 0011 changed to 11 via cfg_load_i (PAT_W=2, overlap=1), then 10 accepted ones -> 9 pulses; count_o saturates at 7 and sat_o=1 after the 8th match; clear_i -> count_o=0, sat_o=0.
- Accept 1,0,1, assert rst_i for one cycle, then accept 1 -> no pulse; count_o=0. Also: cfg_load_i with valid_i=1 and d_i as the final pattern bit -> no pulse; bit discarded.
